conv_stream_tx: RTL and testbench
=================================

CONV_STREAM_TX -- requirements
Module: conv_stream_tx

Interface
REQ-001 Parameter ADDR_W, default 16: pixel-memory address width.
REQ-002 Parameter DIM_W, default 8: width of the width, height and channel-count fields.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to stream one image volume.
REQ-006 img_w, img_h, num_ch  in  DIM_W each  columns, rows, channels (unsigned); latched on accepted start.
REQ-007 base_addr  in  ADDR_W  address of pixel (ch0,row0,col0); latched on accepted start.
REQ-008 pause_in  in  1  suppresses issue of new reads while high.
REQ-009 rd_en / rd_addr  out  1 / ADDR_W  pixel-memory read request.
REQ-010 rd_data  in  8 signed  read data, valid exactly 1 cycle after rd_en.
REQ-011 ima  out  8 signed  pixel to conv, qualified by ena_in.
REQ-012 ena_in  out  1  pixel valid; output names match the conv input side.
REQ-013 frame_start_in, line_start_in, frame_end_in  out  1 each  per-channel frame/row markers.
REQ-014 frame_start_dim_in, frame_end_dim_in  out  1 each  markers for the first/last pixel of the whole channel stack.
REQ-015 busy, done  out  1 each  operation active; one-cycle completion pulse.

Function
REQ-016 FSM states: IDLE, STREAM, DRAIN, FINISH.
- IDLE -> STREAM on start.
- STREAM -> DRAIN after the last read issues.
- DRAIN -> FINISH when the last pixel is output.
- FINISH -> IDLE after one cycle.
REQ-017 start is accepted only in IDLE; start while busy is ignored, with no effect on the stream in progress.
REQ-018 Accepted start with img_w, img_h or num_ch equal to 0: no reads, no ena_in, done pulses the next cycle.
REQ-019 Read order: column fastest, then row, then channel; rd_addr = base_addr + linear index, wrapping modulo 2^ADDR_W.
REQ-020 rd_en first asserts the cycle after start is accepted; afterwards one read per cycle while pause_in is low.
REQ-021 Latency: ena_in/ima appear exactly 2 cycles after the corresponding rd_en; ima is registered from rd_data.
REQ-022 pause_in high in cycle t forces rd_en low in cycle t; the ena_in gap appears in cycle t+2; reads already in flight still output.
REQ-023 Markers are single-cycle and only coincide with ena_in:
- line_start_in on col 0.
- frame_start_in on (row0,col0) of each channel.
- frame_end_in on the last pixel of each channel.
- frame_start_dim_in on ch0 (row0,col0).
- frame_end_dim_in on the last pixel of the last channel.
REQ-024 Markers coincide where geometry requires: img_w=1 gives line_start_in on every pixel; img_w=img_h=1 gives frame_start_in and frame_end_in on one pixel; num_ch=1 gives both dim markers with the frame markers.
REQ-025 busy is high from the cycle after start is accepted through the cycle done pulses; done is high in FINISH only, one cycle after the final ena_in.
REQ-026 Total pixels emitted = img_w*img_h*num_ch exactly (without padding).

Reset
REQ-027 rst_n low at a rising edge forces IDLE and clears all outputs, counters and pipeline valid bits to 0, including mid-stream.
REQ-028 In-flight reads are discarded on reset; no ena_in or marker is emitted in the cycle after reset.

Configuration
REQ-029 Macro CONV_TX_ZERO_PAD_EN defined:
- Emits a (img_w+2)x(img_h+2) frame per channel with a 1-pixel border of ima=0.
- Border pixels issue no reads but keep the same 2-cycle slot timing.
- Markers use the padded geometry.
REQ-030 Macro undefined: no padding logic is compiled; the emitted frame is exactly img_w x img_h.

Structure
REQ-031 Package conv_pkg holds:
- pixel_t, signed 8-bit.
- the FSM state enum.
- a marker struct holding the five marker bits.
- DIM_W/ADDR_W default constants.
REQ-032 Sub-module conv_tx_addr_gen holds col/row/ch counters, linear address, end-of-row/frame/stack flags and padding-border detection; the top holds the FSM, the 2-stage output pipeline and the markers.

Verification
REQ-033 Verification scenario: img_w=4, img_h=3, num_ch=2, base_addr=0x0100, memory holds addr LSBs.
- 24 ena_in pulses; first ena_in 3 cycles after start.
- ima sequence 0x00..0x17.
- 6 line_start_in; frame_start_in at pixels 0 and 12; frame_end_in at 11 and 23.
- done 1 cycle after pixel 23.
REQ-034 Verification scenario: same stream with pause_in high for 3 cycles mid-channel -> 3-cycle ena_in gap 2 cycles later; data order and markers unchanged.
REQ-035 Verification scenario: img_w=1, img_h=1, num_ch=1 -> a single ena_in cycle with all five markers high, then done.
REQ-036 Verification scenario: start with num_ch=0 -> rd_en and ena_in never high; done high the cycle after start; second start while busy in other tests is ignored.
REQ-037 Verification scenario: rst_n low at pixel 5 of a 4x3x2 stream -> all outputs 0 next cycle; a fresh start restarts at base_addr.
REQ-038 Verification scenario: CONV_TX_ZERO_PAD_EN, 2x2x1 image -> 16 pixels; only the centre 4 are nonzero; exactly 4 rd_en pulses; 4 line_start_in.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and default widths for the conv input-side streamer.
package conv_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DIM_W_DEF  = 8;

   typedef logic signed [7:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN,
      FINISH
   } state_t;

   typedef struct packed {
      logic line_start;
      logic frame_start;
      logic frame_end;
      logic frame_start_dim;
      logic frame_end_dim;
   } marker_t;

endpackage

// File: rtl/conv_stream_tx_if.sv
// Command, pixel-memory read and conv-input signals of conv_stream_tx; the slave modport is the block's view.
interface conv_stream_tx_if #(
   parameter int ADDR_W = conv_pkg::ADDR_W_DEF,
   parameter int DIM_W  = conv_pkg::DIM_W_DEF
) ();

   logic                 start;
   logic [DIM_W-1:0]     img_w;
   logic [DIM_W-1:0]     img_h;
   logic [DIM_W-1:0]     num_ch;
   logic [ADDR_W-1:0]    base_addr;
   logic                 pause_in;
   logic                 rd_en;
   logic [ADDR_W-1:0]    rd_addr;
   conv_pkg::pixel_t     rd_data;
   conv_pkg::pixel_t     ima;
   logic                 ena_in;
   logic                 frame_start_in;
   logic                 line_start_in;
   logic                 frame_end_in;
   logic                 frame_start_dim_in;
   logic                 frame_end_dim_in;
   logic                 busy;
   logic                 done;

   modport slave (
      input  start, img_w, img_h, num_ch, base_addr, pause_in, rd_data,
      output rd_en, rd_addr, ima, ena_in, frame_start_in, line_start_in,
             frame_end_in, frame_start_dim_in, frame_end_dim_in, busy, done
   );

   modport master (
      output start, img_w, img_h, num_ch, base_addr, pause_in, rd_data,
      input  rd_en, rd_addr, ima, ena_in, frame_start_in, line_start_in,
             frame_end_in, frame_start_dim_in, frame_end_dim_in, busy, done
   );

endinterface

// File: rtl/conv_tx_addr_gen.sv
// Walks col/row/ch over the emitted frame geometry and tracks the pixel-memory address.
// `CONV_TX_ZERO_PAD_EN grows each frame by a one-pixel border that consumes no address.
module conv_tx_addr_gen
   import conv_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DIM_W  = DIM_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_step,
   input  logic [DIM_W-1:0]  i_img_w,
   input  logic [DIM_W-1:0]  i_img_h,
   input  logic [DIM_W-1:0]  i_num_ch,
   input  logic [ADDR_W-1:0] i_base,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_border,
   output logic              o_col0,
   output logic              o_row0,
   output logic              o_ch0,
   output logic              o_col_last,
   output logic              o_row_last,
   output logic              o_ch_last
);

   // One extra bit so a padded 255-wide frame (257 columns) still fits.
   localparam int CW = DIM_W + 1;

   logic [CW-1:0]     r_col, r_row, r_w, r_h;
   logic [DIM_W-1:0]  r_ch, r_c;
   logic [ADDR_W-1:0] r_addr;
   logic [CW-1:0]     w_w_ld, w_h_ld;

`ifdef CONV_TX_ZERO_PAD_EN
   assign w_w_ld   = {1'b0, i_img_w} + CW'(2);
   assign w_h_ld   = {1'b0, i_img_h} + CW'(2);
   assign o_border = o_col0 | o_row0 | o_col_last | o_row_last;
`else
   assign w_w_ld   = {1'b0, i_img_w};
   assign w_h_ld   = {1'b0, i_img_h};
   assign o_border = 1'b0;
`endif

   assign o_col0     = (r_col == '0);
   assign o_row0     = (r_row == '0);
   assign o_ch0      = (r_ch == '0);
   assign o_col_last = (r_col == r_w - CW'(1));
   assign o_row_last = (r_row == r_h - CW'(1));
   assign o_ch_last  = (r_ch == r_c - DIM_W'(1));
   assign o_addr     = r_addr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_col  <= '0;
         r_row  <= '0;
         r_ch   <= '0;
         r_w    <= '0;
         r_h    <= '0;
         r_c    <= '0;
         r_addr <= '0;
      end else if (i_load) begin
         r_col  <= '0;
         r_row  <= '0;
         r_ch   <= '0;
         r_w    <= w_w_ld;
         r_h    <= w_h_ld;
         r_c    <= i_num_ch;
         r_addr <= i_base;
      end else if (i_step) begin
         // Interior pixels are contiguous in memory, so the address only moves on them.
         if (!o_border) r_addr <= r_addr + ADDR_W'(1);
         if (o_col_last) begin
            r_col <= '0;
            if (o_row_last) begin
               r_row <= '0;
               r_ch  <= r_ch + DIM_W'(1);
            end else begin
               r_row <= r_row + CW'(1);
            end
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

endmodule

// File: rtl/conv_stream_tx.sv
// Streams an img_w x img_h x num_ch volume from pixel memory into the conv input with frame markers.
// Zero-pad border is enabled by defining CONV_TX_ZERO_PAD_EN.
module conv_stream_tx
   import conv_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DIM_W  = DIM_W_DEF
) (
   input logic             clk,
   input logic             rst_n,
   conv_stream_tx_if.slave bus
);

   state_t            r_state, w_next;
   logic              w_load, w_issue, w_zero, w_last_slot;
   logic [ADDR_W-1:0] w_addr;
   logic              w_border, w_col0, w_row0, w_ch0, w_col_last, w_row_last, w_ch_last;
   marker_t           w_mk0, r_mk1, r_mk2;
   logic [2:1]        r_vld_pipe;
   logic              r_pad1;
   pixel_t            r_ima;

   assign w_zero      = (bus.img_w == '0) || (bus.img_h == '0) || (bus.num_ch == '0);
   assign w_load      = (r_state == IDLE) && bus.start;
   assign w_issue     = (r_state == STREAM) && !bus.pause_in;
   assign w_last_slot = w_col_last && w_row_last && w_ch_last;

   conv_tx_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_addr_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_step     (w_issue),
      .i_img_w    (bus.img_w),
      .i_img_h    (bus.img_h),
      .i_num_ch   (bus.num_ch),
      .i_base     (bus.base_addr),
      .o_addr     (w_addr),
      .o_border   (w_border),
      .o_col0     (w_col0),
      .o_row0     (w_row0),
      .o_ch0      (w_ch0),
      .o_col_last (w_col_last),
      .o_row_last (w_row_last),
      .o_ch_last  (w_ch_last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (bus.start) w_next = w_zero ? FINISH : STREAM;
         STREAM:  if (w_issue && w_last_slot) w_next = DRAIN;
         DRAIN:   if (r_vld_pipe[2] && r_mk2.frame_end_dim) w_next = FINISH;
         FINISH:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_mk0                 = '0;
      w_mk0.line_start      = w_col0;
      w_mk0.frame_start     = w_col0 && w_row0;
      w_mk0.frame_end       = w_col_last && w_row_last;
      w_mk0.frame_start_dim = w_col0 && w_row0 && w_ch0;
      w_mk0.frame_end_dim   = w_last_slot;
   end

   // Stage 1 waits out the memory latency; stage 2 registers rd_data (or a zero border) as ima.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld_pipe <= '0;
         r_mk1      <= '0;
         r_mk2      <= '0;
         r_pad1     <= 1'b0;
         r_ima      <= '0;
      end else begin
         r_vld_pipe[1] <= w_issue;
         r_mk1         <= w_issue ? w_mk0 : '0;
         r_pad1        <= w_issue && w_border;
         r_vld_pipe[2] <= r_vld_pipe[1];
         r_mk2         <= r_mk1;
         r_ima         <= (r_vld_pipe[1] && !r_pad1) ? bus.rd_data : '0;
      end
   end

   assign bus.rd_en              = w_issue && !w_border;
   assign bus.rd_addr            = w_addr;
   assign bus.ena_in             = r_vld_pipe[2];
   assign bus.ima                = r_ima;
   assign bus.line_start_in      = r_mk2.line_start;
   assign bus.frame_start_in     = r_mk2.frame_start;
   assign bus.frame_end_in       = r_mk2.frame_end;
   assign bus.frame_start_dim_in = r_mk2.frame_start_dim;
   assign bus.frame_end_dim_in   = r_mk2.frame_end_dim;
   assign bus.busy               = (r_state != IDLE);
   assign bus.done               = (r_state == FINISH);

endmodule

// File: tb/tb_conv_stream_tx.sv
// Randomized scoreboard bench for conv_stream_tx; honours CONV_TX_ZERO_PAD_EN for the padded geometry.
module tb_conv_stream_tx;
   import conv_pkg::*;

   localparam int AW = 16;
   localparam int DW = 8;
`ifdef CONV_TX_ZERO_PAD_EN
   localparam int PAD = 1;
`else
   localparam int PAD = 0;
`endif

   typedef struct { logic border; logic [AW-1:0] addr; logic [7:0] val; logic [4:0] mk; } pix_t;
   typedef struct { int cyc; logic [7:0] val; logic [4:0] mk; } slot_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   bit   chk_en = 1'b0;
   int   ena_cnt = 0, rd_cnt = 0, ls_cnt = 0;

   pix_t  img_q[$];
   slot_t slot_q[$];
   int    m_rem = 0;
   int    m_done_cyc = -1;
   bit    m_busy = 1'b0;
   bit    e_busy = 1'b0, e_done = 1'b0, e_rd = 1'b0;
   logic [AW-1:0] e_addr = '0;

   conv_stream_tx_if #(.ADDR_W(AW), .DIM_W(DW)) bus ();

   conv_stream_tx #(.ADDR_W(AW), .DIM_W(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   // Expected emission order of one accepted start, straight from the geometry rules.
   task automatic build(input int w, input int h, input int c, input logic [AW-1:0] base);
      int W, H, li;
      pix_t p;
      img_q.delete();
      if (w == 0 || h == 0 || c == 0) return;
      W = w + 2 * PAD;
      H = h + 2 * PAD;
      li = 0;
      for (int ch = 0; ch < c; ch++)
         for (int r = 0; r < H; r++)
            for (int col = 0; col < W; col++) begin
               p.border = (PAD != 0) && (col == 0 || r == 0 || col == W - 1 || r == H - 1);
               p.addr   = base + AW'(li);
               if (!p.border) li++;
               p.val = p.border ? 8'h00 : p.addr[7:0];
               p.mk  = {col == 0, col == 0 && r == 0, col == W - 1 && r == H - 1,
                        ch == 0 && col == 0 && r == 0, ch == c - 1 && col == W - 1 && r == H - 1};
               img_q.push_back(p);
            end
   endtask

   // Pixel memory: each word holds its address LSBs, valid only the cycle after rd_en.
   logic          cap_en = 1'b0;
   logic [AW-1:0] cap_a = '0;
   initial forever begin
      @(negedge clk);
      cap_en = bus.rd_en;
      cap_a  = bus.rd_addr;
   end
   initial begin : mem
      logic [31:0] junk;
      bus.rd_data = '0;
      forever begin
         @(posedge clk); #1;
         junk = $urandom;
         bus.rd_data = cap_en ? cap_a[7:0] : (junk[7:0] | 8'h01);
      end
   end

   // Reference model: one slot per cycle while not paused, output two cycles later, done after the last.
   initial begin : model
      pix_t p;
      forever begin
         @(negedge clk);
         e_busy = m_busy;
         e_done = (cyc == m_done_cyc);
         e_rd   = 1'b0;
         e_addr = '0;
         if (m_rem > 0 && !bus.pause_in) begin
            p = img_q.pop_front();
            e_rd   = !p.border;
            e_addr = p.addr;
            slot_q.push_back('{cyc + 2, p.val, p.mk});
            m_rem--;
            if (m_rem == 0) m_done_cyc = cyc + 3;
         end
         if (!rst_n) begin
            m_busy = 1'b0;
            m_rem = 0;
            m_done_cyc = -1;
            img_q.delete();
            while (slot_q.size() > 0 && slot_q[$].cyc > cyc) void'(slot_q.pop_back());
         end else if (!m_busy && bus.start) begin
            m_busy = 1'b1;
            build(int'(bus.img_w), int'(bus.img_h), int'(bus.num_ch), bus.base_addr);
            m_rem = img_q.size();
            if (m_rem == 0) m_done_cyc = cyc + 1;
         end else if (m_busy && e_done) begin
            m_busy = 1'b0;
         end
      end
   end

   // Monitor: compares every cycle's outputs against the model and the slot scoreboard.
   initial begin : monitor
      slot_t s;
      bit exp_v;
      logic [4:0] mk_out;
      forever begin
         @(negedge clk); #2;
         if (chk_en) begin
            mk_out = {bus.line_start_in, bus.frame_start_in, bus.frame_end_in,
                      bus.frame_start_dim_in, bus.frame_end_dim_in};
            check("busy", bus.busy, e_busy);
            check("done", bus.done, e_done);
            check("rd_en", bus.rd_en, e_rd);
            if (e_rd) check("rd_addr", bus.rd_addr, e_addr);
            exp_v = slot_q.size() > 0 && slot_q[0].cyc == cyc;
            check("ena_in", bus.ena_in, exp_v);
            if (exp_v) begin
               s = slot_q.pop_front();
               check("pixel", {bus.ima, mk_out}, {s.val, s.mk});
            end else begin
               check("marker_idle", mk_out, 5'b0);
            end
            while (slot_q.size() > 0 && slot_q[0].cyc <= cyc) begin
               s = slot_q.pop_front();
               check("slot_missed", 0, s.cyc);
            end
            if (bus.ena_in) ena_cnt++;
            if (bus.rd_en) rd_cnt++;
            if (bus.ena_in && bus.line_start_in) ls_cnt++;
         end
      end
   end

   // pmode: 0 no pause, 1 random pause, 2 pause for three cycles mid-channel.
   task automatic run(input int w, input int h, input int c, input int base,
                      input int pmode, input bit junk, input int rst_at);
      bit got, did_rst;
      int n_emit, n_ls;
      got = 1'b0;
      did_rst = 1'b0;
      ena_cnt = 0; rd_cnt = 0; ls_cnt = 0;
      @(posedge clk); #1;
      bus.img_w = DW'(w); bus.img_h = DW'(h); bus.num_ch = DW'(c);
      bus.base_addr = AW'(base); bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.img_w = DW'($urandom_range(0, 7));
      bus.base_addr = AW'($urandom);
      for (int k = 0; k < 3000; k++) begin
         case (pmode)
            1:       bus.pause_in = ($urandom_range(0, 3) == 0);
            2:       bus.pause_in = (k >= 4 && k <= 6);
            default: bus.pause_in = 1'b0;
         endcase
         bus.start = junk && ($urandom_range(0, 7) == 0);
         if (rst_at >= 0 && ena_cnt > rst_at) begin
            rst_n = 1'b0; bus.start = 1'b0; bus.pause_in = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(negedge clk); #3;
            check("reset_clear", {bus.rd_en, bus.rd_addr, bus.ena_in, bus.ima, bus.line_start_in,
                  bus.frame_start_in, bus.frame_end_in, bus.frame_start_dim_in,
                  bus.frame_end_dim_in, bus.busy, bus.done}, 64'd0);
            did_rst = 1'b1;
            break;
         end
         @(negedge clk);
         if (bus.done) begin got = 1'b1; break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0; bus.pause_in = 1'b0;
      if (!did_rst) begin
         check("done_seen", got, 1);
         n_emit = (w == 0 || h == 0 || c == 0) ? 0 : (w + 2 * PAD) * (h + 2 * PAD) * c;
         n_ls   = (n_emit == 0) ? 0 : (h + 2 * PAD) * c;
         check("ena_count", ena_cnt, n_emit);
         check("rd_count", rd_cnt, (n_emit == 0) ? 0 : w * h * c);
         check("line_start_count", ls_cnt, n_ls);
      end
   endtask

   initial begin : driver
      int w, h, c, b;
      bus.start = 1'b0; bus.pause_in = 1'b0;
      bus.img_w = '0; bus.img_h = '0; bus.num_ch = '0; bus.base_addr = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk_en = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;

      run(4, 3, 2, 16'h0100, 0, 1'b0, -1);
      run(4, 3, 2, 16'h0100, 2, 1'b0, -1);
      run(1, 1, 1, 16'h0040, 0, 1'b0, -1);
      run(3, 2, 0, 16'h0100, 0, 1'b0, -1);
      run(0, 5, 2, 16'h0100, 0, 1'b0, -1);
      run(4, 3, 2, 16'h0100, 0, 1'b0, 5);
      run(4, 3, 2, 16'h0100, 0, 1'b0, -1);
      run(2, 2, 1, 16'h0200, 0, 1'b0, -1);
      run(1, 3, 2, 16'hFFF8, 1, 1'b1, -1);
      run(3, 3, 2, 16'hFFFA, 1, 1'b1, -1);
      for (int i = 0; i < 15; i++) begin
         w = $urandom_range(0, 5);
         h = $urandom_range(1, 4);
         c = $urandom_range(0, 3);
         b = $urandom_range(0, 65535);
         run(w, h, c, b, 1, 1'b1, -1);
      end
      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
